// File: rtl/jericalla_pkg.sv
// -----------------------------------------------------------------------------
// jericalla_pkg
// Shared definitions for the jericalla_evo register-file + ALU datapath:
//   - default data/address widths
//   - opcode encoding (opcode_e)
//   - instruction field bit positions, both for the default geometry and as
//     helper functions for any ADDR_W
// Ports: none (package).
// -----------------------------------------------------------------------------
package jericalla_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int OPCODE_W       = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_PASS = 3'b111
  } opcode_e;

  // Instruction layout: opcode | rs1 | rs2 | rd, rd in the low bits.
  function automatic int instr_width(input int addr_w);
    return OPCODE_W + 3 * addr_w;
  endfunction

  function automatic int rd_lsb(input int addr_w);
    return 0 * addr_w;
  endfunction

  function automatic int rs2_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rs1_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int opcode_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  // Field positions for the default 18-bit instruction word.
  localparam int DEFAULT_INSTR_W = OPCODE_W + 3 * DEFAULT_ADDR_W;
  localparam int OPCODE_LSB      = 3 * DEFAULT_ADDR_W;
  localparam int RS1_LSB         = 2 * DEFAULT_ADDR_W;
  localparam int RS2_LSB         = DEFAULT_ADDR_W;
  localparam int RD_LSB          = 0;

endpackage

// File: rtl/jericalla_alu.sv
// -----------------------------------------------------------------------------
// jericalla_alu
// Purely combinational ALU for the jericalla datapath. No carry/overflow is
// produced; every result is truncated to DATA_W bits.
// Ports:
//   a      in   DATA_W  first operand (rs1)
//   b      in   DATA_W  second operand (rs2)
//   op     in   3       opcode (jericalla_pkg::opcode_e)
//   result out  DATA_W  operation result
// -----------------------------------------------------------------------------
module jericalla_alu
  import jericalla_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] result
);

  logic signed_less;

  // Signed comparison for SLT; the result is zero-extended to a 0/1 word.
  always_comb begin
    signed_less = ($signed(a) < $signed(b));
  end

  // Operation select. PASS forwards A unchanged; the default arm keeps the
  // block latch-free even though every encoding is covered.
  always_comb begin
    result = a;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, signed_less};
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/jericalla_evo.sv
// -----------------------------------------------------------------------------
// jericalla_evo
// Single-cycle register-file machine: every rising edge executes the current
// instruction, writing the ALU result to RF[rd] and to the output registers.
// There is no write enable and register 0 is an ordinary register.
// Ports:
//   clk_jericalla      in   1        sole clock, rising edge
//   rst_n_jericalla    in   1        asynchronous active-low reset
//   instruccion        in   3+3*AW   {opcode, rs1, rs2, rd}
//   dataOut_jericalla  out  DATA_W   registered result of last instruction
//   zf_jericalla       out  1        registered zero flag of that result
// -----------------------------------------------------------------------------
module jericalla_evo
  import jericalla_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                          clk_jericalla,
  input  logic                          rst_n_jericalla,
  input  logic [OPCODE_W+3*ADDR_W-1:0]  instruccion,
  output logic [DATA_W-1:0]             dataOut_jericalla,
  output logic                          zf_jericalla
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int OPC_LSB  = opcode_lsb(ADDR_W);
  localparam int RS1_POS  = rs1_lsb(ADDR_W);
  localparam int RS2_POS  = rs2_lsb(ADDR_W);
  localparam int RD_POS   = rd_lsb(ADDR_W);

  logic [DATA_W-1:0] reg_file [NUM_REGS];

  opcode_e           op;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;

  // Instruction decode and combinational register reads. Reads see the
  // pre-edge contents, so an rd that aliases a source uses the old value.
  always_comb begin
    op        = opcode_e'(instruccion[OPC_LSB +: OPCODE_W]);
    rs1       = instruccion[RS1_POS +: ADDR_W];
    rs2       = instruccion[RS2_POS +: ADDR_W];
    rd        = instruccion[RD_POS  +: ADDR_W];
    operand_a = reg_file[rs1];
    operand_b = reg_file[rs2];
  end

  jericalla_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (operand_a),
    .b      (operand_b),
    .op     (op),
    .result (alu_result)
  );

  // Register file write plus output registers. Reset preloads RF[i] = i so
  // the machine has useful operands without any load instruction; the
  // output starts at 0 with the zero flag set to match.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= DATA_W'(i);
      end
      dataOut_jericalla <= '0;
      zf_jericalla      <= 1'b1;
    end else begin
      reg_file[rd]      <= alu_result;
      dataOut_jericalla <= alu_result;
      zf_jericalla      <= (alu_result == '0);
    end
  end

endmodule

// File: tb/tb_jericalla_evo.sv
// -----------------------------------------------------------------------------
// tb_jericalla_evo
// Self-checking bench for jericalla_evo: directed sequences with known
// results, then randomized instructions compared with a behavioural model of
// the register machine kept as a plain array.
// -----------------------------------------------------------------------------
module tb_jericalla_evo;

  logic        clk;
  logic        rst_n;
  logic [17:0] instr;
  logic [31:0] data_out;
  logic        zf;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_data;
  logic        model_zf;

  jericalla_evo dut (
    .clk_jericalla     (clk),
    .rst_n_jericalla   (rst_n),
    .instruccion       (instr),
    .dataOut_jericalla (data_out),
    .zf_jericalla      (zf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input int op, input int rs1,
                                     input int rs2, input int rd);
    mk = {3'(op), 5'(rs1), 5'(rs2), 5'(rd)};
  endfunction

  // Reset state of the machine as described: RF[i] = i, output 0, flag set.
  task automatic resetModel();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'(i);
    model_data = 32'd0;
    model_zf   = 1'b1;
  endtask

  // Result of one instruction on the current architectural state.
  function automatic logic [31:0] refResult(input logic [17:0] ins);
    logic [31:0] a;
    logic [31:0] b;
    longint      sa;
    longint      sb;
    a  = model_regs[ins[14:10]];
    b  = model_regs[ins[9:5]];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ins[17:15])
      3'd0:    refResult = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1:    refResult = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd2:    refResult = a & b;
      3'd3:    refResult = a | b;
      3'd4:    refResult = a ^ b;
      3'd5:    refResult = ~(a | b);
      3'd6:    refResult = (sa < sb) ? 32'd1 : 32'd0;
      default: refResult = a;
    endcase
  endfunction

  // Drive one instruction, let one rising edge execute it, advance the
  // model, and leave time 1 unit after the edge for sampling.
  task automatic applyStimulus(input logic [17:0] ins);
    logic [31:0] res;
    instr = ins;
    @(posedge clk);
    res = refResult(ins);
    model_regs[ins[4:0]] = res;
    model_data = res;
    model_zf   = (res == 32'd0);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_data,
                             input logic exp_zf);
    checks++;
    assert (data_out === exp_data) else begin
      errors++;
      $error("[TB] FAIL %s dataOut: got %h expected %h", tag, data_out, exp_data);
    end
    checks++;
    assert (zf === exp_zf) else begin
      errors++;
      $error("[TB] FAIL %s zf: got %b expected %b", tag, zf, exp_zf);
    end
  endtask

  // Hold one instruction for several edges; the first edge is checked
  // against the hand-derived constant, later edges against the model.
  task automatic runDirected(input string tag, input logic [17:0] ins,
                             input logic [31:0] exp_data, input logic exp_zf,
                             input int hold);
    applyStimulus(ins);
    checkOutput(tag, exp_data, exp_zf);
    for (int k = 1; k < hold; k++) begin
      applyStimulus(ins);
      checkOutput($sformatf("%s_hold%0d", tag, k), model_data, model_zf);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 18'd0;
    resetModel();
    #12;
    checkOutput("reset_state", 32'd0, 1'b1);
    rst_n = 1'b1;

    $display("[TB] directed arithmetic sequence");
    runDirected("add_r4_r1_r0", mk(0, 4, 1, 0), 32'd5, 1'b0, 5);
    runDirected("sub_r5_r1_r2", mk(1, 5, 1, 2), 32'd4, 1'b0, 5);
    runDirected("and_r6_r2_r3", mk(2, 6, 2, 3), 32'd4, 1'b0, 5);
    runDirected("or_r0_r4_r7",  mk(3, 0, 4, 7), 32'd5, 1'b0, 5);
    runDirected("or_r0_r5_r8",  mk(3, 0, 5, 8), 32'd5, 1'b0, 5);
    runDirected("or_r0_r6_r9",  mk(3, 0, 6, 9), 32'd7, 1'b0, 5);

    $display("[TB] zero, wrap and signed compare");
    runDirected("sub_zero_r10",  mk(1, 1, 1, 10),  32'd0,         1'b1, 2);
    runDirected("clear_r0",      mk(1, 1, 1, 0),   32'd0,         1'b1, 1);
    runDirected("sub_wrap_r11",  mk(1, 0, 1, 11),  32'hFFFF_FFFF, 1'b0, 2);
    runDirected("set_r31",       mk(1, 0, 1, 31),  32'hFFFF_FFFF, 1'b0, 1);
    runDirected("slt_r31_r1",    mk(6, 31, 1, 12), 32'd1,         1'b0, 2);
    runDirected("slt_r1_r31",    mk(6, 1, 31, 13), 32'd0,         1'b1, 2);
    runDirected("xor_r31_r2",    mk(4, 31, 2, 14), 32'hFFFF_FFFB, 1'b0, 1);
    runDirected("nor_r0_r0",     mk(5, 0, 0, 15),  32'hFFFF_FFFF, 1'b0, 1);

    $display("[TB] randomized instructions against the model");
    for (int n = 0; n < 200; n++) begin
      logic [17:0] ins;
      int          hold;
      ins  = mk($urandom_range(7), $urandom_range(31),
                $urandom_range(31), $urandom_range(31));
      hold = $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) begin
        applyStimulus(ins);
        checkOutput($sformatf("rand%0d_%0d_ins%h", n, k, ins), model_data, model_zf);
      end
    end

    $display("[TB] asynchronous reset between edges");
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async_reset", 32'd0, 1'b1);
    #2;
    rst_n = 1'b1;
    runDirected("pass_r7_after_reset", mk(7, 7, 0, 16), 32'd7, 1'b0, 1);
    runDirected("pass_r0_after_reset", mk(7, 0, 3, 17), 32'd0, 1'b1, 1);

    $display("[TB] alias re-execution from reset");
    #2;
    rst_n = 1'b0;
    #2;
    resetModel();
    rst_n = 1'b1;
    runDirected("alias_add_1", mk(0, 1, 1, 1), 32'd2, 1'b0, 1);
    runDirected("alias_add_2", mk(0, 1, 1, 1), 32'd4, 1'b0, 1);
    runDirected("alias_add_3", mk(0, 1, 1, 1), 32'd8, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
